cpu_paddle_ctrl: RTL and testbench
==================================

Name: cpu_paddle_ctrl

Overview:
- Automatic opponent controller for a paddle.
- Consumes ball position/direction and the paddle's current top/bottom; generates the up/down move requests that the paddle block consumes.
- Sits in the top-level game beside the paddle instance, replacing player buttons on one side.
- Reaction delay, speed divider and dead zone keep it beatable.

Parameters:
- DeadZone, 8: max |target − paddle centre| (pixels) for which no move is issued.
- StepDiv, 4: issue at most one move pulse every StepDiv clocks (≥2).
- ReactDelay, 16: clocks between ball turning toward the paddle and tracking start (≥1).
- sHeight, 600: screen height; down never requested when paddle bottom ≥ sHeight.
- HomeY, 300: centre y the paddle returns to while the ball moves away.

Ports:
- PixelClock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  1 = controller active; 0 = idle, no moves.
- ballTop  in  11  ball top y.
- ballBottom  in  11  ball bottom y.
- ballDirX  in  1  1 = ball travelling toward this paddle.
- barTop  in  11  paddle top y (from paddle block).
- barBottom  in  11  paddle bottom y (from paddle block).
- up  out  1  registered one-cycle move-up request.
- down  out  1  registered one-cycle move-down request.
- tracking  out  1  registered; 1 while in TRACK.

Behaviour:
- Reset (sampled at edge): state=IDLE, up=0, down=0, tracking=0, reactCnt=0, stepCnt=0. Reset overrides all other inputs, including mid-TRACK.
- Arithmetic:
  - ballC = (ballTop+ballBottom)>>1 and barC = (barTop+barBottom)>>1, sums taken at 12 bits so there is no overflow.
  - target = ballC in TRACK, HomeY in HOME.
  - err = target − barC, 12-bit signed.
- States:
  - IDLE: up=down=0. If Enable=1, go to HOME when ballDirX=0; otherwise go to REACT with reactCnt=ReactDelay−1.
  - HOME: steps toward HomeY. ballDirX=1 → REACT, load reactCnt=ReactDelay−1.
  - REACT: no moves. reactCnt decrements each clock. At the edge seeing reactCnt==0 → TRACK. ballDirX=0 in REACT → HOME (abandon delay).
  - TRACK: steps toward ballC. ballDirX=0 → HOME.
- Enable=0 at any edge → IDLE, up=down=0 at that edge.
- Step generation in HOME/TRACK:
  - stepCnt clears to 0 on entry to HOME/TRACK and counts 0..StepDiv−1, wrapping.
  - At the edge where stepCnt==StepDiv−1:
    - err > DeadZone and barBottom < sHeight → down=1.
    - err < −DeadZone and barTop > 1 → up=1.
    - otherwise neither is set.
  - At all other edges up=down=0. Each pulse lasts exactly one clock; up and down are never both 1.
  - |err|==DeadZone exactly → no move (strict comparisons).
- tracking=1 exactly for the clocks where the registered state is TRACK.
- Latency: Enable=1 with ballDirX=1 sampled at edge 0 from IDLE → TRACK after edge ReactDelay → first pulse registered at edge ReactDelay+StepDiv, then every StepDiv clocks.
- Inputs are used combinationally at each edge; no additional input registering.

Test Plan:
- Reset=1 for 3 clocks, any inputs → up=down=tracking=0, state IDLE; release with Enable=0 → outputs stay 0 indefinitely.
- Tracking down:
  - Defaults; Enable=1, ballDirX=1, ball 395..405 (ballC=400), bar 225..375 (barC=300), asserted at edge 0.
  - Required: tracking=1 from edge 16; down=1 for one clock after edge 20, 24, 28, …; up stays 0.
- Dead zone: as above but ballC=308 (err=8) → no pulses; ballC=309 → down pulses; ballC=291 (err=−9) → up pulses.
- Screen limits:
  - barBottom=600 with err=+100 → down never asserted.
  - barTop=1 with err=−100 → up never asserted.
- Direction flip: ballDirX drops at edge 10 during REACT → HOME, tracking never 1; bar 225..375 (barC=300, err 0) → no pulses; bar 300..450 (barC=375) → up pulses every 4 clocks starting edge 15.
- Interrupts:
  - Reset=1 mid-TRACK coincident with a pulse edge → up=down=0 that edge, state IDLE; restart needs the full 16-clock reaction delay.
  - Enable=0 mid-TRACK → same outputs and state.

Source files
------------

// File: rtl/cpu_paddle_ctrl.sv
// Automatic opponent for one paddle: follows the ball while it approaches and
// returns to a home position while it recedes. Reaction delay, step rate and dead zone keep it beatable.
module cpu_paddle_ctrl #(
    parameter int DeadZone   = 8,
    parameter int StepDiv    = 4,
    parameter int ReactDelay = 16,
    parameter int sHeight    = 600,
    parameter int HomeY      = 300
) (
    input  logic        PixelClock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [10:0] ballTop,
    input  logic [10:0] ballBottom,
    input  logic        ballDirX,
    input  logic [10:0] barTop,
    input  logic [10:0] barBottom,
    output logic        up,
    output logic        down,
    output logic        tracking
);

    localparam int RW = (ReactDelay > 1) ? $clog2(ReactDelay) : 1;
    localparam int SW = $clog2(StepDiv);

    localparam logic [RW-1:0]        REACT_LOAD = RW'(ReactDelay - 1);
    localparam logic [SW-1:0]        STEP_LAST  = SW'(StepDiv - 1);
    localparam logic signed [11:0]   DZ_POS     = 12'(DeadZone);
    localparam logic signed [11:0]   DZ_NEG     = 12'(-DeadZone);
    localparam logic [10:0]          S_HEIGHT   = 11'(sHeight);
    localparam logic [11:0]          HOME_Y     = 12'(HomeY);

    typedef enum logic [1:0] {
        IDLE,
        HOME,
        REACT,
        TRACK
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   react_cnt, react_cnt_nxt;
    logic [SW-1:0]   step_cnt, step_cnt_nxt;
    logic            up_nxt, down_nxt;

    logic [11:0]        ball_c, bar_c, target;
    logic signed [11:0] err;
    logic               step_due, want_up, want_down;

    // Centres use 12-bit sums so two 11-bit coordinates never overflow.
    assign ball_c    = ({1'b0, ballTop} + {1'b0, ballBottom}) >> 1;
    assign bar_c     = ({1'b0, barTop} + {1'b0, barBottom}) >> 1;
    assign target    = (state == TRACK) ? ball_c : HOME_Y;
    assign err       = $signed(target - bar_c);
    assign step_due  = (step_cnt == STEP_LAST);
    assign want_down = (err > DZ_POS) && (barBottom < S_HEIGHT);
    assign want_up   = (err < DZ_NEG) && (barTop > 11'd1);

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        react_cnt_nxt = react_cnt;
        step_cnt_nxt  = step_cnt;
        up_nxt        = 1'b0;
        down_nxt      = 1'b0;

        if (!Enable) begin
            state_nxt     = IDLE;
            react_cnt_nxt = '0;
            step_cnt_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ballDirX) begin
                        state_nxt     = REACT;
                        react_cnt_nxt = REACT_LOAD;
                    end else begin
                        state_nxt    = HOME;
                        step_cnt_nxt = '0;
                    end
                end
                REACT: begin
                    if (!ballDirX) begin
                        state_nxt    = HOME;
                        step_cnt_nxt = '0;
                    end else if (react_cnt == '0) begin
                        state_nxt    = TRACK;
                        step_cnt_nxt = '0;
                    end else begin
                        react_cnt_nxt = react_cnt - RW'(1);
                    end
                end
                HOME, TRACK: begin
                    if (state == HOME && ballDirX) begin
                        state_nxt     = REACT;
                        react_cnt_nxt = REACT_LOAD;
                    end else if (state == TRACK && !ballDirX) begin
                        state_nxt    = HOME;
                        step_cnt_nxt = '0;
                    end else begin
                        // A transition edge never pulses; stepping only within a stay.
                        step_cnt_nxt = step_due ? '0 : step_cnt + SW'(1);
                        if (step_due) begin
                            up_nxt   = want_up;
                            down_nxt = want_down;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge PixelClock) begin
        if (Reset) begin
            state     <= IDLE;
            react_cnt <= '0;
            step_cnt  <= '0;
            up        <= 1'b0;
            down      <= 1'b0;
            tracking  <= 1'b0;
        end else begin
            state     <= state_nxt;
            react_cnt <= react_cnt_nxt;
            step_cnt  <= step_cnt_nxt;
            up        <= up_nxt;
            down      <= down_nxt;
            tracking  <= (state_nxt == TRACK);
        end
    end

    assert property (@(posedge PixelClock) !(up && down));

endmodule

// File: tb/tb_cpu_paddle_ctrl.sv
// Scoreboard bench for cpu_paddle_ctrl: expected output triples are queued as each
// edge's stimulus is driven and compared once the edge has registered.
module tb_cpu_paddle_ctrl;

    localparam int REACT = 16;
    localparam int STEP  = 4;

    logic        PixelClock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [10:0] ballTop, ballBottom, barTop, barBottom;
    logic        ballDirX;
    logic        up, down, tracking;

    typedef struct packed {
        logic up;
        logic down;
        logic trk;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    cpu_paddle_ctrl dut (
        .PixelClock (PixelClock),
        .Reset      (Reset),
        .Enable     (Enable),
        .ballTop    (ballTop),
        .ballBottom (ballBottom),
        .ballDirX   (ballDirX),
        .barTop     (barTop),
        .barBottom  (barBottom),
        .up         (up),
        .down       (down),
        .tracking   (tracking)
    );

    always #5 PixelClock = ~PixelClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: queue the expectation for this edge, let it register, then compare.
    task automatic tick(input string tag, input logic eu, input logic ed, input logic et);
        exp_t e;
        exp_t o;
        e.up   = eu;
        e.down = ed;
        e.trk  = et;
        sb_q.push_back(e);
        @(posedge PixelClock);
        #1;
        o = sb_q.pop_front();
        check(tag, 32'({up, down, tracking}), 32'({o.up, o.down, o.trk}));
    endtask

    task automatic set_pos(input int bt, input int bb, input int rt, input int rb);
        ballTop    = 11'(bt);
        ballBottom = 11'(bb);
        barTop     = 11'(rt);
        barBottom  = 11'(rb);
    endtask

    task automatic idle_reset();
        Reset    = 1'b1;
        Enable   = 1'b0;
        ballDirX = 1'b0;
        tick("rst", 1'b0, 1'b0, 1'b0);
        tick("rst", 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        tick("idle", 1'b0, 1'b0, 1'b0);
    endtask

    // mode: 0 no pulses, 1 down pulses, 2 up pulses. flip >= 0 drops ballDirX after that edge.
    task automatic scenario(input string tag, input int bt, input int bb, input int rt, input int rb,
                            input int mode, input int flip, input int n);
        int   first;
        logic pulse, trk;
        idle_reset();
        set_pos(bt, bb, rt, rb);
        Enable   = 1'b1;
        ballDirX = 1'b1;
        first    = (flip < 0) ? REACT + STEP : flip + 1 + STEP;
        for (int k = 0; k < n; k++) begin
            if (flip >= 0 && k > flip) ballDirX = 1'b0;
            trk   = (flip < 0) && (k >= REACT);
            pulse = (k >= first) && ((k - first) % STEP == 0);
            tick(tag, pulse && mode == 2, pulse && mode == 1, trk);
        end
    endtask

    // Track downward, interrupt at pulse edge 24, then restart from scratch at edge 25.
    task automatic interrupt(input string tag, input logic use_reset);
        int   j;
        logic pulse, trk;
        idle_reset();
        set_pos(395, 405, 225, 375);
        Enable   = 1'b1;
        ballDirX = 1'b1;
        for (int k = 0; k < 54; k++) begin
            if (k == 24) begin
                if (use_reset) Reset = 1'b1;
                else Enable = 1'b0;
            end
            if (k == 25) begin
                Reset  = 1'b0;
                Enable = 1'b1;
            end
            j     = (k < 24) ? k : k - 25;
            trk   = (k != 24) && (j >= REACT);
            pulse = (k != 24) && (j >= REACT + STEP) && ((j - REACT - STEP) % STEP == 0);
            tick(tag, 1'b0, pulse, trk);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        Enable   = 1'b1;
        ballDirX = 1'b1;
        set_pos(395, 405, 225, 375);
        for (int i = 0; i < 3; i++) tick("reset_hold", 1'b0, 1'b0, 1'b0);
        Reset  = 1'b0;
        Enable = 1'b0;
        for (int i = 0; i < 40; i++) tick("disabled", 1'b0, 1'b0, 1'b0);

        scenario("track_down",  395, 405, 225, 375, 1, -1, 36);
        scenario("dz_edge",     303, 313, 225, 375, 0, -1, 32);
        scenario("dz_down",     304, 314, 225, 375, 1, -1, 32);
        scenario("dz_up",       286, 296, 225, 375, 2, -1, 32);
        scenario("bottom_lim",  620, 630, 450, 600, 0, -1, 32);
        scenario("bottom_ok",   620, 630, 449, 599, 1, -1, 32);
        scenario("top_lim",     295, 305,   1, 799, 0, -1, 32);
        scenario("top_ok",      295, 305,   2, 800, 2, -1, 32);
        scenario("flip_centre", 395, 405, 225, 375, 0, 10, 32);
        scenario("flip_up",     395, 405, 300, 450, 2, 10, 32);

        interrupt("int_reset",  1'b1);
        interrupt("int_enable", 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
